// File: rtl/serial_cascade_comparator_if.sv
// Request/result bus of the serial cascade comparator.
// Handshake: start is a request and is taken on the rising edge where busy=0; busy=1 means not ready and start is dropped.
interface serial_cascade_comparator_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             err;

  modport master (
    output start, a, b,
    input  busy, done, eq, gt, lt, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, eq, gt, lt, err
  );
endinterface

// File: rtl/serial_cascade_comparator.sv
// Streams two WIDTH-bit operands LSB nibble first through an external 4-bit cascade
// comparator stage, feeding its registered outputs back as the next cascade inputs.
module serial_cascade_comparator #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_cascade_comparator_if.slave bus,
  output logic [3:0]                 nib_a,
  output logic [3:0]                 nib_b,
  output logic                       cas_eq,
  output logic                       cas_gt,
  output logic                       cas_lt,
  input  logic                       cmp_eq,
  input  logic                       cmp_gt,
  input  logic                       cmp_lt,
  output logic                       dbgState
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             accEq;
  logic             accGt;
  logic             accLt;
  logic             doneReg;
  logic             eqReg;
  logic             gtReg;
  logic             ltReg;
  logic             errReg;
  logic             running;
  logic             tripleOk;

  assign running  = (state == RUN);
  assign tripleOk = $onehot({cmp_eq, cmp_gt, cmp_lt});

  // Idle drive is a neutral "equal so far" seed so the stage output is well defined.
  assign nib_a  = running ? sa[3:0] : 4'h0;
  assign nib_b  = running ? sb[3:0] : 4'h0;
  assign cas_eq = running ? accEq : 1'b1;
  assign cas_gt = running ? accGt : 1'b0;
  assign cas_lt = running ? accLt : 1'b0;

  assign bus.busy = running;
  assign bus.done = doneReg;
  assign bus.eq   = eqReg;
  assign bus.gt   = gtReg;
  assign bus.lt   = ltReg;
  assign bus.err  = errReg;
  assign dbgState = state[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      accEq   <= 1'b1;
      accGt   <= 1'b0;
      accLt   <= 1'b0;
      doneReg <= 1'b0;
      eqReg   <= 1'b0;
      gtReg   <= 1'b0;
      ltReg   <= 1'b0;
      errReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            cnt    <= '0;
            accEq  <= 1'b1;
            accGt  <= 1'b0;
            accLt  <= 1'b0;
            errReg <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          accEq <= cmp_eq;
          accGt <= cmp_gt;
          accLt <= cmp_lt;
          sa    <= sa >> 4;
          sb    <= sb >> 4;
          cnt   <= cnt + CW'(1);
          if (!tripleOk) errReg <= 1'b1;
          // The stage output for the top nibble already folds in every lower nibble.
          if (cnt == LAST) begin
            eqReg   <= cmp_eq;
            gtReg   <= cmp_gt;
            ltReg   <= cmp_lt;
            doneReg <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_cascade_comparator.sv
// Bench for serial_cascade_comparator: behavioural 4-bit stage model downstream,
// operand results predicted with plain magnitude comparison.
module tb_serial_cascade_comparator;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic       cas_eq;
  logic       cas_gt;
  logic       cas_lt;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       cmp_lt;
  logic       dbgState;
  logic       faultInj;

  int checkCnt = 0;
  int passCnt  = 0;

  serial_cascade_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_cascade_comparator #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .nib_a    (nib_a),
    .nib_b    (nib_b),
    .cas_eq   (cas_eq),
    .cas_gt   (cas_gt),
    .cas_lt   (cas_lt),
    .cmp_eq   (cmp_eq),
    .cmp_gt   (cmp_gt),
    .cmp_lt   (cmp_lt),
    .dbgState (dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit cascade stage: a nibble difference overrides the cascade inputs.
  always_comb begin
    {cmp_eq, cmp_gt, cmp_lt} = {cas_eq, cas_gt, cas_lt};
    if (faultInj)           {cmp_eq, cmp_gt, cmp_lt} = 3'b011;
    else if (nib_a > nib_b) {cmp_eq, cmp_gt, cmp_lt} = 3'b010;
    else if (nib_a < nib_b) {cmp_eq, cmp_gt, cmp_lt} = 3'b001;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver: called at a negedge while idle (or in the done cycle); returns one negedge after the accepting edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  // Scoreboard: waits (bounded) for done and checks latency and result against plain arithmetic.
  task automatic awaitResult(input string tag, input logic [15:0] av, input logic [15:0] bv,
                             input logic expErr, input int already);
    int cycles = already;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkVal({tag, "_latency"}, cycles, NIB);
    checkVal({tag, "_eq"}, bus.eq, (av == bv));
    checkVal({tag, "_gt"}, bus.gt, (av > bv));
    checkVal({tag, "_lt"}, bus.lt, (av < bv));
    checkVal({tag, "_err"}, bus.err, expErr);
    checkVal({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        doneSeen;
    rst_n     = 1'b0;
    faultInj  = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset values while held
    repeat (2) @(negedge clk);
    checkVal("reset_outs", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.err,
                            nib_a, nib_b, cas_eq, cas_gt, cas_lt}, {6'b0, 8'h00, 3'b100});
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands
    issue(16'hA5A5, 16'hA5A5);
    checkVal("eq_busy", bus.busy, 1'b1);
    awaitResult("equal", 16'hA5A5, 16'hA5A5, 1'b0, 0);
    @(negedge clk);
    checkVal("done_pulse_width", bus.done, 1'b0);
    checkVal("idle_drive", {nib_a, nib_b, cas_eq, cas_gt, cas_lt}, {8'h00, 3'b100});

    // MSB dominates; low nibble alone would say less
    issue(16'h8000, 16'h7FFF);
    checkVal("msb_nib0", {nib_a, nib_b}, {4'h0, 4'hF});
    checkVal("msb_cas_seed", {cas_eq, cas_gt, cas_lt}, 3'b100);
    @(negedge clk);
    checkVal("msb_acc_nib0", {cas_eq, cas_gt, cas_lt},
             {(4'h0 == 4'hF), (4'h0 > 4'hF), (4'h0 < 4'hF)});
    checkVal("msb_nib1", {nib_a, nib_b}, {4'h0, 4'hF});
    awaitResult("msb", 16'h8000, 16'h7FFF, 1'b0, 1);

    // Low-nibble tie-break both ways
    @(negedge clk);
    issue(16'h1235, 16'h1234);
    awaitResult("tie_gt", 16'h1235, 16'h1234, 1'b0, 0);
    @(negedge clk);
    issue(16'h1234, 16'h1235);
    awaitResult("tie_lt", 16'h1234, 16'h1235, 1'b0, 0);

    // Back-to-back: start in the done cycle, plus an ignored mid-run start
    @(negedge clk);
    issue(16'h0300, 16'h0200);
    awaitResult("b2b_first", 16'h0300, 16'h0200, 1'b0, 0);
    issue(16'h0001, 16'h0002);
    checkVal("b2b_accept_busy", bus.busy, 1'b1);
    checkVal("b2b_done_clear", bus.done, 1'b0);
    checkVal("b2b_hold_prev", {bus.eq, bus.gt, bus.lt}, 3'b010);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    checkVal("b2b_hold_mid", {bus.eq, bus.gt, bus.lt}, 3'b010);
    awaitResult("b2b_second", 16'h0001, 16'h0002, 1'b0, 2);
    @(negedge clk);
    checkVal("ignored_start_no_run", bus.busy, 1'b0);

    // Protocol fault on nibble 0, then cleared by the next start
    issue(16'h9000, 16'h1000);
    faultInj = 1'b1;
    @(negedge clk);
    faultInj = 1'b0;
    awaitResult("fault", 16'h9000, 16'h1000, 1'b1, 1);
    @(negedge clk);
    checkVal("err_sticky_idle", bus.err, 1'b1);
    issue(16'h0042, 16'h0042);
    checkVal("err_cleared_on_start", bus.err, 1'b0);
    awaitResult("after_fault", 16'h0042, 16'h0042, 1'b0, 0);

    // Randomized: equal, single-nibble difference, or unrelated operands
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: rb = 16'($urandom);
      endcase
      issue(ra, rb);
      awaitResult($sformatf("rand%0d", i), ra, rb, 1'b0, 0);
    end

    // Reset mid-run: asynchronous abort, no done afterwards
    @(negedge clk);
    issue(16'h1234, 16'h4321);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("midrun_reset_async", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.err,
                                    nib_a, nib_b, cas_eq, cas_gt, cas_lt}, {6'b0, 8'h00, 3'b100});
    @(negedge clk);
    checkVal("midrun_reset_held", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.err},
             6'b0);
    rst_n    = 1'b1;
    doneSeen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      doneSeen = doneSeen | bus.done | bus.busy;
    end
    checkVal("no_done_after_reset", doneSeen, 1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
